// File: rtl/dcache_responder_if.sv
// Bundle of the datapath-side request bus and the memory-controller bus
// around the data cache. The slave modport is the cache itself; the master
// modport is its environment: the datapath plus the memory controller.
interface dcache_responder_if;
    // datapath request side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    // memory controller side
    logic        cdREN;
    logic        cdWEN;
    logic [31:0] cdaddr;
    logic [31:0] cdstore;
    logic [31:0] cdload;
    logic        cdwait;

    modport slave (
        input  dREN, dWEN, daddr, dstore, halt, cdload, cdwait,
        output dhit, dmemload, flushed, cdREN, cdWEN, cdaddr, cdstore
    );

    modport master (
        output dREN, dWEN, daddr, dstore, halt, cdload, cdwait,
        input  dhit, dmemload, flushed, cdREN, cdWEN, cdaddr, cdstore
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with 2-word blocks.
// Serves datapath requests in IDLE, handles misses with an optional
// write-back followed by a 2-beat refill, and on halt flushes every dirty
// block before raising flushed.
// Optional feature: define DCACHE_HIT_COUNTER_EN to count first-try hits and
// write the count to CNT_ADDR as the final step of the flush.
module dcache_responder #(
    parameter int SETS = 8
`ifdef DCACHE_HIT_COUNTER_EN
    ,
    parameter logic [31:0] CNT_ADDR = 32'h0000_3100
`endif
) (
    input  logic               CLK,
    input  logic               nRST,
    dcache_responder_if.slave  dc
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 3;
    localparam logic [IDX_W:0] LAST_SET = (IDX_W + 1)'(SETS - 1);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [3:0] {
        S_IDLE, S_WB0, S_WB1, S_LD0, S_LD1,
        S_FLUSH, S_FWB0, S_FWB1,
`ifdef DCACHE_HIT_COUNTER_EN
        S_CNT,
`endif
        S_DONE
    } state_e;

`ifdef DCACHE_HIT_COUNTER_EN
    localparam state_e FLUSH_END = S_CNT;
`else
    localparam state_e FLUSH_END = S_DONE;
`endif

    // per-set storage
    logic        valid_q [SETS];
    logic        dirty_q [SETS];
    tag_t        tag_q   [SETS];
    logic [31:0] word0_q [SETS];
    logic [31:0] word1_q [SETS];

    state_e          state_q, state_d;
    logic [IDX_W:0]  set_q, set_d;   // one spare bit so the last set never wraps

`ifdef DCACHE_HIT_COUNTER_EN
    logic [31:0] cnt_q, cnt_d;
    logic        miss_q, miss_d;
`endif

    // request decode; the datapath holds the request until dhit
    tag_t  req_tag;
    idx_t  req_idx;
    logic  req_off;
    logic  req_any;
    logic  hit;
    logic  unused_addr_bits;
    idx_t  flush_idx;

    assign req_tag          = dc.daddr[31:IDX_W+3];
    assign req_idx          = dc.daddr[IDX_W+2:3];
    assign req_off          = dc.daddr[2];
    assign req_any          = dc.dREN | dc.dWEN;
    assign hit              = req_any & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign unused_addr_bits = ^dc.daddr[1:0];
    assign flush_idx        = set_q[IDX_W-1:0];

    // storage update strobes produced by the FSM
    logic hit_wr;
    logic ld_we0;
    logic ld_we1;
    logic fill_done;
    logic flush_clr;

    // next-state, bus outputs and storage strobes
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        set_d        = set_q;
        dc.dhit      = 1'b0;
        dc.dmemload  = '0;
        dc.flushed   = 1'b0;
        dc.cdREN     = 1'b0;
        dc.cdWEN     = 1'b0;
        dc.cdaddr    = '0;
        dc.cdstore   = '0;
        hit_wr       = 1'b0;
        ld_we0       = 1'b0;
        ld_we1       = 1'b0;
        fill_done    = 1'b0;
        flush_clr    = 1'b0;
`ifdef DCACHE_HIT_COUNTER_EN
        cnt_d        = cnt_q;
        miss_d       = miss_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (dc.halt) begin
                    state_d = S_FLUSH;
                    set_d   = '0;
                end else if (hit) begin
                    dc.dhit     = 1'b1;
                    dc.dmemload = req_off ? word1_q[req_idx] : word0_q[req_idx];
                    hit_wr      = dc.dWEN;   // dREN and dWEN together act as a write
`ifdef DCACHE_HIT_COUNTER_EN
                    if (!miss_q) cnt_d = cnt_q + 32'd1;
                    miss_d = 1'b0;
`endif
                end else if (req_any) begin
                    state_d = dirty_q[req_idx] ? S_WB0 : S_LD0;
`ifdef DCACHE_HIT_COUNTER_EN
                    miss_d  = 1'b1;
`endif
                end
            end

            S_WB0, S_WB1: begin
                dc.cdWEN   = 1'b1;
                dc.cdaddr  = {tag_q[req_idx], req_idx, state_q == S_WB1, 2'b00};
                dc.cdstore = (state_q == S_WB1) ? word1_q[req_idx] : word0_q[req_idx];
                if (!dc.cdwait) state_d = (state_q == S_WB1) ? S_LD0 : S_WB1;
            end

            S_LD0, S_LD1: begin
                dc.cdREN  = 1'b1;
                dc.cdaddr = {req_tag, req_idx, state_q == S_LD1, 2'b00};
                if (!dc.cdwait) begin
                    if (state_q == S_LD1) begin
                        ld_we1    = 1'b1;
                        fill_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ld_we0  = 1'b1;
                        state_d = S_LD1;
                    end
                end
            end

            S_FLUSH: begin
                if (dirty_q[flush_idx]) begin
                    state_d = S_FWB0;
                end else begin
                    flush_clr = 1'b1;
                    if (set_q == LAST_SET) state_d = FLUSH_END;
                    else                   set_d   = set_q + 1'b1;
                end
            end

            S_FWB0, S_FWB1: begin
                dc.cdWEN   = 1'b1;
                dc.cdaddr  = {tag_q[flush_idx], flush_idx, state_q == S_FWB1, 2'b00};
                dc.cdstore = (state_q == S_FWB1) ? word1_q[flush_idx] : word0_q[flush_idx];
                if (!dc.cdwait) begin
                    if (state_q == S_FWB1) begin
                        flush_clr = 1'b1;
                        if (set_q == LAST_SET) begin
                            state_d = FLUSH_END;
                        end else begin
                            set_d   = set_q + 1'b1;
                            state_d = S_FLUSH;
                        end
                    end else begin
                        state_d = S_FWB1;
                    end
                end
            end

`ifdef DCACHE_HIT_COUNTER_EN
            S_CNT: begin
                dc.cdWEN   = 1'b1;
                dc.cdaddr  = CNT_ADDR;
                dc.cdstore = cnt_q;
                if (!dc.cdwait) state_d = S_DONE;
            end
`endif

            S_DONE: begin
                dc.flushed = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and flush set counter
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!nRST) begin
            state_q <= S_IDLE;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
        end
    end

    // valid/dirty bits: cleared on reset so nothing from an aborted fill survives
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            if (hit_wr) dirty_q[req_idx] <= 1'b1;
            if (fill_done) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
            if (flush_clr) begin
                valid_q[flush_idx] <= 1'b0;
                dirty_q[flush_idx] <= 1'b0;
            end
        end
    end

    // tag and data arrays: written on write hits and refill beats
    always_ff @(posedge CLK) begin
        // NOTE: tag/data arrays are left unreset; valid_q gates every use, so their contents are don't-care.
        if (hit_wr) begin
            if (req_off) word1_q[req_idx] <= dc.dstore;
            else         word0_q[req_idx] <= dc.dstore;
        end
        if (ld_we0)    word0_q[req_idx] <= dc.cdload;
        if (ld_we1)    word1_q[req_idx] <= dc.cdload;
        if (fill_done) tag_q[req_idx]   <= req_tag;
    end

`ifdef DCACHE_HIT_COUNTER_EN
    // hit counter and the flag that excludes the hit ending a miss
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            miss_q <= miss_d;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed testbench for dcache_responder: a small memory model with a
// fixed 2-cycle wait per beat logs every completed transfer, and a linear
// sequence of requests checks hits, misses, write-back, flush and reset.
module tb_dcache_responder;
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    dcache_responder_if dc ();

    dcache_responder u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .dc   (dc)
    );

    int checks = 0;
    int errors = 0;

    localparam int LAT = 2;
    logic [31:0] mem [logic [31:0]];
    logic        log_wr   [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    int          wcnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int i, input logic wr,
                             input logic [31:0] a, input logic [31:0] d);
        if (i < log_addr.size()) begin
            check({tag, ".wr"},   32'(log_wr[i]), 32'(wr));
            check({tag, ".addr"}, log_addr[i], a);
            check({tag, ".data"}, log_data[i], d);
        end else begin
            check({tag, ".present"}, 32'(log_addr.size()), 32'(i + 1));
        end
    endtask

    // memory controller model: holds cdwait high LAT cycles, then completes
    initial begin
        dc.cdwait = 1'b0;
        dc.cdload = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (!nRST) begin
                wcnt      = 0;
                dc.cdwait = 1'b0;
            end else if (dc.cdREN || dc.cdWEN) begin
                if (wcnt == LAT) begin
                    wcnt      = 0;
                    dc.cdwait = 1'b0;
                    if (dc.cdWEN) begin
                        mem[dc.cdaddr] = dc.cdstore;
                        log_data.push_back(dc.cdstore);
                    end else begin
                        dc.cdload = mem.exists(dc.cdaddr) ? mem[dc.cdaddr] : 32'h0;
                        log_data.push_back(dc.cdload);
                    end
                    log_wr.push_back(dc.cdWEN);
                    log_addr.push_back(dc.cdaddr);
                end else begin
                    wcnt++;
                    dc.cdwait = 1'b1;
                end
            end else begin
                wcnt      = 0;
                dc.cdwait = 1'b0;
            end
        end
    end

    // issue one request and hold it until dhit (bounded)
    task automatic req(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] data, output logic [31:0] load, output int cyc);
        @(negedge CLK);
        dc.dREN = ren; dc.dWEN = wen; dc.daddr = addr; dc.dstore = data;
        #1;
        cyc = 0;
        while (dc.dhit !== 1'b1 && cyc < 200) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        check("req_dhit", 32'(dc.dhit), 32'd1);
        load = dc.dmemload;
        @(posedge CLK);
        #1;
        dc.dREN = 1'b0;
        dc.dWEN = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ld;
        int          cyc;
        int          n;
        int          base;

        nRST = 1'b0;
        dc.halt = 1'b0;
        dc.dREN = 1'b1; dc.dWEN = 1'b0; dc.daddr = 32'h44; dc.dstore = '0;
        mem[32'h40]  = 32'hAAAA_0001; mem[32'h44]  = 32'hAAAA_0002;
        mem[32'h140] = 32'hBBBB_0001; mem[32'h144] = 32'hBBBB_0002;
        mem[32'h08]  = 32'hC000_0008; mem[32'h0C]  = 32'hC000_000C;
        mem[32'h28]  = 32'hE000_0028; mem[32'h2C]  = 32'hE000_002C;
        mem[32'h50]  = 32'hF000_0050; mem[32'h54]  = 32'hF000_0054;

        // reset state, with a request already presented
        repeat (2) @(negedge CLK);
        #1;
        check("rst.dhit",     32'(dc.dhit),    32'd0);
        check("rst.dmemload", dc.dmemload,     32'd0);
        check("rst.flushed",  32'(dc.flushed), 32'd0);
        check("rst.cdREN",    32'(dc.cdREN),   32'd0);
        check("rst.cdWEN",    32'(dc.cdWEN),   32'd0);
        check("rst.cdaddr",   dc.cdaddr,       32'd0);
        check("rst.cdstore",  dc.cdstore,      32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        dc.dREN = 1'b0;

        // cold read miss on the upper word
        req(1'b1, 1'b0, 32'h44, 32'h0, ld, cyc);
        check("cold.data", ld, 32'hAAAA_0002);
        check("cold.missed", 32'(cyc > 0), 32'd1);
        check("cold.beats", 32'(log_addr.size()), 32'd2);
        check_log("cold.b0", 0, 1'b0, 32'h40, 32'hAAAA_0001);
        check_log("cold.b1", 1, 1'b0, 32'h44, 32'hAAAA_0002);

        // same-cycle hit on the other word, no memory traffic
        req(1'b1, 1'b0, 32'h40, 32'h0, ld, cyc);
        check("rehit.data", ld, 32'hAAAA_0001);
        check("rehit.cyc", 32'(cyc), 32'd0);
        check("rehit.beats", 32'(log_addr.size()), 32'd2);

        // write hit
        req(1'b0, 1'b1, 32'h44, 32'h1234_5678, ld, cyc);
        check("wrhit.cyc", 32'(cyc), 32'd0);
        check("wrhit.beats", 32'(log_addr.size()), 32'd2);

        // conflict miss: write back dirty block, then refill
        req(1'b1, 1'b0, 32'h144, 32'h0, ld, cyc);
        check("conf.data", ld, 32'hBBBB_0002);
        check("conf.beats", 32'(log_addr.size()), 32'd6);
        check_log("conf.wb0", 2, 1'b1, 32'h40,  32'hAAAA_0001);
        check_log("conf.wb1", 3, 1'b1, 32'h44,  32'h1234_5678);
        check_log("conf.ld0", 4, 1'b0, 32'h140, 32'hBBBB_0001);
        check_log("conf.ld1", 5, 1'b0, 32'h144, 32'hBBBB_0002);

        // dREN and dWEN together behave as a write
        req(1'b1, 1'b0, 32'h08, 32'h0, ld, cyc);
        check("both.fill", ld, 32'hC000_0008);
        req(1'b1, 1'b1, 32'h08, 32'hDEAD_0008, ld, cyc);
        check("both.cyc", 32'(cyc), 32'd0);
        req(1'b1, 1'b0, 32'h08, 32'h0, ld, cyc);
        check("both.readback", ld, 32'hDEAD_0008);
        check("both.beats", 32'(log_addr.size()), 32'd8);

        // write miss allocates, then writes the upper word of set 5
        req(1'b0, 1'b1, 32'h2C, 32'h5555_AAAA, ld, cyc);
        check("wrmiss.beats", 32'(log_addr.size()), 32'd10);
        req(1'b1, 1'b0, 32'h2C, 32'h0, ld, cyc);
        check("wrmiss.readback", ld, 32'h5555_AAAA);
        check("wrmiss.cyc", 32'(cyc), 32'd0);

        // halt: flush dirty sets 1 and 5 in set order, then flushed
        @(negedge CLK);
        dc.halt = 1'b1;
        dc.dREN = 1'b1; dc.daddr = 32'h44;
        #1;
        check("halt.nohit", 32'(dc.dhit), 32'd0);
        n = 0;
        while (dc.flushed !== 1'b1 && n < 500) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("flush.flushed", 32'(dc.flushed), 32'd1);
        check_log("flush.s1w0", 10, 1'b1, 32'h08, 32'hDEAD_0008);
        check_log("flush.s1w1", 11, 1'b1, 32'h0C, 32'hC000_000C);
        check_log("flush.s5w0", 12, 1'b1, 32'h28, 32'hE000_0028);
        check_log("flush.s5w1", 13, 1'b1, 32'h2C, 32'h5555_AAAA);
`ifdef DCACHE_HIT_COUNTER_EN
        check_log("flush.cnt", 14, 1'b1, 32'h3100, 32'd5);
        check("flush.beats", 32'(log_addr.size()), 32'd15);
`else
        check("flush.beats", 32'(log_addr.size()), 32'd14);
`endif
        repeat (3) @(negedge CLK);
        #1;
        check("done.dhit",    32'(dc.dhit),    32'd0);
        check("done.cdREN",   32'(dc.cdREN),   32'd0);
        check("done.cdWEN",   32'(dc.cdWEN),   32'd0);
        check("done.flushed", 32'(dc.flushed), 32'd1);

        // leave DONE through reset
        nRST = 1'b0;
        dc.halt = 1'b0;
        dc.dREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("rerst.flushed", 32'(dc.flushed), 32'd0);

        // reset asserted during LD1 while memory is stalling
        @(negedge CLK);
        dc.dREN = 1'b1; dc.daddr = 32'h54;
        n = 0;
        while (!(dc.cdREN === 1'b1 && dc.cdaddr === 32'h54 && dc.cdwait === 1'b1) && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("abort.reached_ld1", 32'(dc.cdaddr), 32'h54);
        nRST = 1'b0;
        #1;
        check("abort.dhit",     32'(dc.dhit),    32'd0);
        check("abort.dmemload", dc.dmemload,     32'd0);
        check("abort.cdREN",    32'(dc.cdREN),   32'd0);
        check("abort.cdWEN",    32'(dc.cdWEN),   32'd0);
        check("abort.cdaddr",   dc.cdaddr,       32'd0);
        check("abort.flushed",  32'(dc.flushed), 32'd0);
        dc.dREN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        base = log_addr.size();
        nRST = 1'b1;

        // the aborted address must miss again
        req(1'b1, 1'b0, 32'h54, 32'h0, ld, cyc);
        check("after.data", ld, 32'hF000_0054);
        check("after.missed", 32'(cyc > 0), 32'd1);
        check_log("after.ld0", base,     1'b0, 32'h50, 32'hF000_0050);
        check_log("after.ld1", base + 1, 1'b0, 32'h54, 32'hF000_0054);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
